// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and helpers for the traffic-light sequencer.
package traffic_light_fsm_pkg;

  // Encoding is consumed downstream by pwm_driver; 2'b11 is never driven.
  typedef enum logic [1:0] {
    StRed    = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } state_e;

  localparam int unsigned TickCntW = 8;

  // Last tick_cnt value of a phase lasting `ticks` ticks.
  function automatic logic [TickCntW-1:0] last_tick(int unsigned ticks);
    return TickCntW'(ticks - 1);
  endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Control inputs and light-state outputs of the traffic-light sequencer.
interface traffic_light_fsm_if;
  import traffic_light_fsm_pkg::*;

  logic                enable;
  logic                ped_req;
  logic                emergency;
  state_e              traffic_state;
  logic                state_changed;
  logic                ped_pending;
  logic [TickCntW-1:0] remain_ticks;

  modport master (
    output enable, ped_req, emergency,
    input  traffic_state, state_changed, ped_pending, remain_ticks
  );

  modport slave (
    input  enable, ped_req, emergency,
    output traffic_state, state_changed, ped_pending, remain_ticks
  );

endinterface

// File: rtl/traffic_light_fsm_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks, frozen while disabled.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = enable && (cnt_q == CntMax);

  // Count 0..TICK_DIV-1 and wrap; hold value when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer: RED -> GREEN -> YELLOW on tick timers, with pedestrian
// shortening of GREEN and an emergency hold in RED.
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned RED_TICKS       = 30,
  parameter int unsigned GREEN_TICKS     = 25,
  parameter int unsigned YELLOW_TICKS    = 5,
  parameter int unsigned MIN_GREEN_TICKS = 10
) (
  input logic                clk,
  input logic                rst_n,
  traffic_light_fsm_if.slave bus
);

  localparam logic [TickCntW-1:0] RedLast      = last_tick(RED_TICKS);
  localparam logic [TickCntW-1:0] GreenLast    = last_tick(GREEN_TICKS);
  localparam logic [TickCntW-1:0] YellowLast   = last_tick(YELLOW_TICKS);
  localparam logic [TickCntW-1:0] MinGreenLast = last_tick(MIN_GREEN_TICKS);

  logic                tick;
  state_e              state_q;
  logic [TickCntW-1:0] tick_cnt_q;
  logic                ped_q;
  logic                changed_q;
  logic [TickCntW-1:0] duration;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(bus.enable),
    .tick  (tick)
  );

  // Sequencer state, phase timer, pedestrian latch and change pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRed;
      tick_cnt_q <= '0;
      ped_q      <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      // Latching is independent of enable; a RED-entry clear below overrides it.
      if (bus.ped_req && (state_q == StGreen || state_q == StYellow)) begin
        ped_q <= 1'b1;
      end
      case (state_q)
        StRed: begin
          if (bus.enable) begin
            if (bus.emergency) begin
              tick_cnt_q <= '0;
            end else if (tick) begin
              if (tick_cnt_q == RedLast) begin
                state_q    <= StGreen;
                tick_cnt_q <= '0;
                changed_q  <= 1'b1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
        end
        StGreen: begin
          if (bus.enable) begin
            if (bus.emergency) begin
              state_q    <= StYellow;
              tick_cnt_q <= '0;
              changed_q  <= 1'b1;
            end else if (tick) begin
              if (tick_cnt_q == GreenLast || (ped_q && tick_cnt_q >= MinGreenLast)) begin
                state_q    <= StYellow;
                tick_cnt_q <= '0;
                changed_q  <= 1'b1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
        end
        StYellow: begin
          if (bus.enable && tick) begin
            if (tick_cnt_q == YellowLast) begin
              state_q    <= StRed;
              tick_cnt_q <= '0;
              changed_q  <= 1'b1;
              ped_q      <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // Unreachable encoding (upset or forced): recover to RED immediately.
          state_q    <= StRed;
          tick_cnt_q <= '0;
          changed_q  <= 1'b1;
          ped_q      <= 1'b0;
        end
      endcase
    end
  end

  // Duration of the current phase for the remaining-ticks readout.
  always_comb begin
    duration = TickCntW'(RED_TICKS);
    case (state_q)
      StGreen:  duration = TickCntW'(GREEN_TICKS);
      StYellow: duration = TickCntW'(YELLOW_TICKS);
      default:  duration = TickCntW'(RED_TICKS);
    endcase
  end

  assign bus.traffic_state = state_q;
  assign bus.state_changed = changed_q;
  assign bus.ped_pending   = ped_q;
  assign bus.remain_ticks  = duration - tick_cnt_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench: stimulus queues expected transitions, a monitor checks each change.
module tb_traffic_light_fsm;
  import traffic_light_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    state_e      st;
    int unsigned dur;  // clocks spent in the previous state; 0 = not checked
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  traffic_light_fsm_if tl_if ();

  traffic_light_fsm #(
    .TICK_DIV       (4),
    .RED_TICKS      (3),
    .GREEN_TICKS    (6),
    .YELLOW_TICKS   (2),
    .MIN_GREEN_TICKS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (tl_if.slave)
  );

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push(input state_e st, input int unsigned dur);
    exp_t e;
    e.st  = st;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // Advance to the next cycle showing a state_changed pulse; n = negedges waited.
  task automatic wait_change(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tl_if.state_changed && n < 200);
    if (!tl_if.state_changed) begin
      tests++;
      fails++;
      $display("FAIL %s: no state change within %0d cycles", name, n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: pop one expectation per state_changed pulse and check state and dwell time.
  initial begin
    int unsigned last;
    exp_t        e;
    last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last = cyc;
      end else if (tl_if.state_changed) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: state %0d at cycle %0d", tl_if.traffic_state, cyc);
        end else begin
          e = exp_q.pop_front();
          check("mon_state", int'(tl_if.traffic_state), int'(e.st));
          if (e.dur != 0) check("mon_dwell", int'(cyc - last), int'(e.dur));
        end
        last = cyc;
      end
    end
  end

  initial begin
    int     n;
    state_e bad_st;
    bad_st          = state_e'(2'b11);
    rst_n           = 1'b0;
    tl_if.enable    = 1'b1;
    tl_if.ped_req   = 1'b0;
    tl_if.emergency = 1'b0;
    idle(3);
    check("rst_state", int'(tl_if.traffic_state), int'(StRed));
    check("rst_changed", int'(tl_if.state_changed), 0);
    check("rst_ped", int'(tl_if.ped_pending), 0);
    check("rst_remain", int'(tl_if.remain_ticks), 3);

    // 1: free-running cycle
    push(StGreen, 12);
    push(StYellow, 24);
    push(StRed, 8);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_remain", int'(tl_if.remain_ticks), 3);
    wait_change("t1_green", n);
    check("t1_green_remain", int'(tl_if.remain_ticks), 6);
    wait_change("t1_yellow", n);
    wait_change("t1_red", n);
    check("t1_ped", int'(tl_if.ped_pending), 0);

    // 2: pedestrian pulse at the start of GREEN shortens it to 2 ticks
    push(StGreen, 12);
    push(StYellow, 8);
    push(StRed, 8);
    wait_change("t2_green", n);
    tl_if.ped_req = 1'b1;
    @(negedge clk);
    tl_if.ped_req = 1'b0;
    check("t2_ped_set", int'(tl_if.ped_pending), 1);
    wait_change("t2_yellow", n);
    check("t2_ped_yellow", int'(tl_if.ped_pending), 1);
    wait_change("t2_red", n);
    check("t2_ped_clear", int'(tl_if.ped_pending), 0);

    // 3: request held through RED is ignored
    tl_if.ped_req = 1'b1;
    push(StGreen, 12);
    push(StYellow, 24);
    push(StRed, 8);
    wait_change("t3_green", n);
    tl_if.ped_req = 1'b0;
    check("t3_ped", int'(tl_if.ped_pending), 0);
    wait_change("t3_yellow", n);
    wait_change("t3_red", n);

    // 4: emergency at GREEN tick_cnt=3, hold RED, then full RED on release
    push(StGreen, 12);
    push(StYellow, 16);
    push(StRed, 8);
    push(StGreen, 64);
    wait_change("t4_green", n);
    idle(15);
    check("t4_green_remain", int'(tl_if.remain_ticks), 3);
    tl_if.emergency = 1'b1;
    wait_change("t4_yellow", n);
    check("t4_yellow_latency", n, 1);
    check("t4_yellow_remain", int'(tl_if.remain_ticks), 2);
    wait_change("t4_red", n);
    idle(25);
    check("t4_hold_remain", int'(tl_if.remain_ticks), 3);
    idle(27);
    check("t4_hold_state", int'(tl_if.traffic_state), int'(StRed));
    check("t4_hold_remain2", int'(tl_if.remain_ticks), 3);
    tl_if.emergency = 1'b0;
    wait_change("t4_release", n);
    check("t4_red_after_release", n, 12);

    // 5: freeze for 20 clocks at RED tick_cnt=1
    push(StYellow, 24);
    push(StRed, 8);
    push(StGreen, 32);
    wait_change("t5_yellow", n);
    wait_change("t5_red", n);
    idle(4);
    check("t5_remain_pre", int'(tl_if.remain_ticks), 2);
    @(negedge clk);
    tl_if.enable = 1'b0;
    idle(20);
    check("t5_frozen_state", int'(tl_if.traffic_state), int'(StRed));
    check("t5_frozen_remain", int'(tl_if.remain_ticks), 2);
    tl_if.enable = 1'b1;
    wait_change("t5_green", n);
    check("t5_resume", n, 7);

    // 6: reset mid-GREEN with a pending request
    tl_if.ped_req = 1'b1;
    @(negedge clk);
    tl_if.ped_req = 1'b0;
    @(negedge clk);
    check("t6_ped_set", int'(tl_if.ped_pending), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_state", int'(tl_if.traffic_state), int'(StRed));
    check("t6_remain", int'(tl_if.remain_ticks), 3);
    check("t6_ped", int'(tl_if.ped_pending), 0);
    check("t6_changed", int'(tl_if.state_changed), 0);

    // Illegal encoding recovers to RED with a change pulse
    idle(3);
    push(StRed, 0);
    push(StGreen, 0);
    force dut.state_q = bad_st;
    #1;
    release dut.state_q;
    wait_change("t6_illegal", n);
    check("t6_illegal_latency", n, 1);
    check("t6_illegal_remain", int'(tl_if.remain_ticks), 3);
    wait_change("t6_green", n);

    idle(2);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
